// File: rtl/minicpu_pkg.sv
// Shared types and field widths for the minicpu controller and its ALU.
package minicpu_pkg;

    localparam int unsigned OpcodeWidth = 4;
    localparam int unsigned ImmWidth    = 4;
    localparam int unsigned InstrWidth  = OpcodeWidth + ImmWidth;
    localparam int unsigned DataWidth   = 4;

    typedef enum logic [OpcodeWidth-1:0] {
        OpAddA   = 4'b0000,
        OpMovAB  = 4'b0001,
        OpInA    = 4'b0010,
        OpMovAIm = 4'b0011,
        OpMovBA  = 4'b0100,
        OpAddB   = 4'b0101,
        OpInB    = 4'b0110,
        OpMovBIm = 4'b0111,
        OpOutB   = 4'b1001,
        OpOutIm  = 4'b1011,
        OpJnc    = 4'b1110,
        OpJmp    = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        StHalt,
        StFetch,
        StExec
    } state_e;

endpackage

// File: rtl/minicpu_alu.sv
// 4-bit adder with carry-out, used by ADD A,Im and ADD B,Im.
module minicpu_alu
    import minicpu_pkg::*;
(
    input  logic [DataWidth-1:0] i_a,
    input  logic [DataWidth-1:0] i_b,
    output logic [DataWidth-1:0] o_sum,
    output logic                 o_carry
);

    logic [DataWidth:0] w_sum;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum   = w_sum[DataWidth-1:0];
    assign o_carry = w_sum[DataWidth];

endmodule

// File: rtl/minicpu_ctrl.sv
// Two-cycle fetch/execute controller for a 4-bit accumulator CPU with an external ROM.
module minicpu_ctrl
    import minicpu_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  step,
    output logic [3:0]            rom_addr,
    input  logic [InstrWidth-1:0] rom_data,
    input  logic [DataWidth-1:0]  in_port,
    output logic [DataWidth-1:0]  out_port,
    output logic                  busy,
    output logic                  instr_done,
    output logic [3:0]            pc,
    output logic [DataWidth-1:0]  reg_a,
    output logic [DataWidth-1:0]  reg_b,
    output logic                  carry
);

    state_e                 r_state;
    logic [3:0]             r_pc;
    logic [InstrWidth-1:0]  r_ir;
    logic [DataWidth-1:0]   r_a;
    logic [DataWidth-1:0]   r_b;
    logic [DataWidth-1:0]   r_out;
    logic                   r_carry;

    opcode_e                w_op;
    logic [ImmWidth-1:0]    w_imm;
    logic [DataWidth-1:0]   w_alu_a;
    logic [DataWidth-1:0]   w_sum;
    logic                   w_cout;

    assign w_op    = opcode_e'(r_ir[InstrWidth-1:ImmWidth]);
    assign w_imm   = r_ir[ImmWidth-1:0];
    assign w_alu_a = (w_op == OpAddB) ? r_b : r_a;

    minicpu_alu u_alu (
        .i_a     (w_alu_a),
        .i_b     (w_imm),
        .o_sum   (w_sum),
        .o_carry (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StHalt;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                StHalt: begin
                    if (run || step) r_state <= StFetch;
                end
                StFetch: begin
                    r_ir    <= rom_data;
                    r_state <= StExec;
                end
                StExec: begin
                    // Defaults for every non-ADD, non-jump instruction; cases below override.
                    r_carry <= 1'b0;
                    r_pc    <= r_pc + 4'd1;
                    case (w_op)
                        OpAddA: begin
                            r_a     <= w_sum;
                            r_carry <= w_cout;
                        end
                        OpAddB: begin
                            r_b     <= w_sum;
                            r_carry <= w_cout;
                        end
                        OpMovAIm: r_a   <= w_imm;
                        OpMovBIm: r_b   <= w_imm;
                        OpMovAB:  r_a   <= r_b;
                        OpMovBA:  r_b   <= r_a;
                        OpInA:    r_a   <= in_port;
                        OpInB:    r_b   <= in_port;
                        OpOutB:   r_out <= r_b;
                        OpOutIm:  r_out <= w_imm;
                        OpJmp:    r_pc  <= w_imm;
                        // r_carry here is the flag left by the previous instruction.
                        OpJnc: begin
                            if (!r_carry) r_pc <= w_imm;
                        end
                        default: ;
                    endcase
                    r_state <= run ? StFetch : StHalt;
                end
                default: r_state <= StHalt;
            endcase
        end
    end

    assign rom_addr   = r_pc;
    assign pc         = r_pc;
    assign reg_a      = r_a;
    assign reg_b      = r_b;
    assign carry      = r_carry;
    assign out_port   = r_out;
    assign busy       = (r_state != StHalt);
    assign instr_done = (r_state == StExec);

endmodule

// File: tb/tb_minicpu_ctrl.sv
// Directed bench for minicpu_ctrl: a vector table walked in run mode plus multi-cycle corner cases.
module tb_minicpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic       busy;
    logic       instr_done;
    logic [3:0] pc;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic       carry;

    logic [7:0] rom [16];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    minicpu_ctrl #(.RESET_PC(4'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .in_port    (in_port),
        .out_port   (out_port),
        .busy       (busy),
        .instr_done (instr_done),
        .pc         (pc),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .carry      (carry)
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] instr;
        logic [3:0] in_val;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_c;
        logic [3:0] exp_out;
        logic [3:0] exp_pc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 16; i++) rom[i] = val;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int cnt_done;
        int cnt_busy;
        int n_bad;

        // addr, instr, in, A, B, C, OUT, PC after execution
        vecs[0]  = '{4'h0, 8'h3F, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h1};
        vecs[1]  = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h2};
        vecs[2]  = '{4'h2, 8'hE9, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h3};
        vecs[3]  = '{4'h3, 8'h7A, 4'h0, 4'h0, 4'hA, 1'b0, 4'h0, 4'h4};
        vecs[4]  = '{4'h4, 8'h56, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h5};
        vecs[5]  = '{4'h5, 8'h55, 4'h0, 4'h0, 4'h5, 1'b0, 4'h0, 4'h6};
        vecs[6]  = '{4'h6, 8'hE8, 4'h0, 4'h0, 4'h5, 1'b0, 4'h0, 4'h8};
        vecs[7]  = '{4'h8, 8'hB7, 4'h0, 4'h0, 4'h5, 1'b0, 4'h7, 4'h9};
        vecs[8]  = '{4'h9, 8'h26, 4'h9, 4'h9, 4'h5, 1'b0, 4'h7, 4'hA};
        vecs[9]  = '{4'hA, 8'h40, 4'h0, 4'h9, 4'h9, 1'b0, 4'h7, 4'hB};
        vecs[10] = '{4'hB, 8'h90, 4'h0, 4'h9, 4'h9, 1'b0, 4'h9, 4'hC};
        vecs[11] = '{4'hC, 8'h6C, 4'hE, 4'h9, 4'hE, 1'b0, 4'h9, 4'hD};
        vecs[12] = '{4'hD, 8'h12, 4'h0, 4'hE, 4'hE, 1'b0, 4'h9, 4'hE};
        vecs[13] = '{4'hE, 8'h52, 4'h0, 4'hE, 4'h0, 1'b1, 4'h9, 4'hF};
        vecs[14] = '{4'hF, 8'hA5, 4'h0, 4'hE, 4'h0, 1'b0, 4'h9, 4'h0};
        vecs[15] = '{4'h0, 8'h3F, 4'h0, 4'hF, 4'h0, 1'b0, 4'h9, 4'h1};

        // Reset state, observed while reset is still held.
        rst_n = 1'b0; run = 1'b0; step = 1'b0; in_port = 4'h0;
        fill_rom(8'h00);
        #1;
        check("reset_regs", {pc, reg_a, reg_b, out_port, carry}, 17'h0);
        check("reset_ctrl", {busy, instr_done, rom_addr}, 6'h0);

        // Table walk in free-running mode.
        fill_rom(8'hF7);
        for (int i = 0; i < 16; i++) rom[vecs[i].addr] = vecs[i].instr;
        do_reset();
        check("idle_after_reset", {busy, pc}, 5'h0);
        in_port = vecs[0].in_val;
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_port = vecs[i].in_val;
            wait_done(ok);
            if (!ok) begin
                n_total++;
                $display("FAIL vec%0d_timeout: no instr_done, expected one within 10 cycles", i);
                break;
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {reg_a, reg_b, carry, out_port, pc},
                  {vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c, vecs[i].exp_out, vecs[i].exp_pc});
        end
        run = 1'b0;

        // Example program: IN A; MOV B,0; ADD A,1 x2; MOV B,A; OUT B; JMP 6.
        fill_rom(8'h00);
        rom[0] = 8'h20; rom[1] = 8'h70; rom[2] = 8'h01; rom[3] = 8'h01;
        rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hF6;
        do_reset();
        in_port = 4'h3;
        run = 1'b1;
        n_bad = 0;
        cnt_done = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (instr_done) cnt_done++;
            if (instr_done !== (k % 2 == 0)) n_bad++;
            if (k == 13) check("prog_out_at_13", out_port, 4'h5);
        end
        check("prog_done_pattern", n_bad, 0);
        check("prog_done_count", cnt_done, 15);
        check("prog_final", {out_port, pc, reg_a, reg_b}, 16'h5655);
        repeat (4) @(negedge clk);
        check("prog_pc_stays", pc, 4'h6);
        run = 1'b0;

        // Single stepping: first pulse is two cycles wide; the extra cycle lands in FETCH.
        fill_rom(8'h01);
        do_reset();
        cnt_done = 0;
        cnt_busy = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy) cnt_busy++;
            if (instr_done) cnt_done++;
            step = (i == 0 || i == 1 || i == 5 || i == 10);
        end
        check("step_done_count", cnt_done, 3);
        check("step_busy_count", cnt_busy, 6);
        check("step_pc_a", {pc, reg_a}, 8'h33);

        // run and step together behave as run.
        do_reset();
        run = 1'b1;
        step = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instr_done) cnt_done++;
        end
        check("run_step_done_count", cnt_done, 4);
        run = 1'b0;
        step = 1'b0;

        // Dropping run mid-instruction lets it retire, then halts.
        do_reset();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("run_drop_retires", instr_done, 1'b1);
        repeat (3) @(negedge clk);
        check("run_drop_halted", {busy, pc, reg_a}, 9'h011);

        // Reset during EXEC of ADD A,1 with A=4.
        fill_rom(8'h00);
        rom[0] = 8'h34;
        rom[1] = 8'h01;
        do_reset();
        run = 1'b1;
        wait_done(ok);
        if (ok) wait_done(ok);
        if (!ok) begin
            n_total++;
            $display("FAIL rst_exec_timeout: no second instr_done, expected one");
        end
        check("rst_exec_pre", {reg_a, pc}, 8'h41);
        rst_n = 1'b0;
        #1;
        check("rst_exec_abort", {reg_a, pc, carry, busy, instr_done}, 11'h0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_exec_stays_halt", {busy, pc, reg_a}, 9'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/minicpu_ctrl.md
MINICPU_CTRL -- requirements
Module: minicpu_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 4'h0, program counter value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: run  input  1  level; 1 = free-running execution.
REQ-005 SHALL have port: step  input  1  single-cycle pulse; executes one instruction while halted.
REQ-006 SHALL have port: rom_addr  output  4  instruction address to the program ROM; always equals pc.
REQ-007 SHALL have port: rom_data  input  8  instruction byte returned combinationally by the ROM ([7:4] opcode, [3:0] immediate).
REQ-008 SHALL have port: in_port  input  4  general input port.
REQ-009 SHALL have port: out_port  output  4  registered output port.
REQ-010 SHALL have ports: busy  output  1 (state != HALT); instr_done  output  1 (one-cycle pulse per retired instruction).
REQ-011 SHALL have debug ports: pc  output  4; reg_a  output  4; reg_b  output  4; carry  output  1.

Function
REQ-012 SHALL implement FSM states HALT, FETCH, EXEC.
REQ-013 HALT -> FETCH when run=1, or when step=1; otherwise HALT holds.
REQ-014 FETCH: SHALL latch rom_data into ir; -> EXEC unconditionally.
REQ-015 EXEC: SHALL update registers, carry, out_port and pc per ir; SHALL assert instr_done for that cycle; -> FETCH if run=1, else -> HALT.
REQ-016 Latency: exactly 2 cycles per instruction; no stalls.
REQ-017 Opcodes (Im = ir[3:0]): 0000 ADD A,Im; 0101 ADD B,Im; 0011 MOV A,Im; 0111 MOV B,Im; 0001 MOV A,B; 0100 MOV B,A; 0010 IN A; 0110 IN B; 1001 OUT B; 1011 OUT Im; 1111 JMP Im; 1110 JNC Im.
REQ-018 ADD SHALL be 4-bit modulo-16 with carry = bit 4 of the 5-bit sum.
REQ-019 Every non-ADD instruction SHALL clear carry.
REQ-020 JNC SHALL load pc=Im when carry (value before this EXEC) is 0; else pc+1.
REQ-021 JMP SHALL load pc=Im; all other instructions pc = pc+1 modulo 16 (15 wraps to 0).
REQ-022 Undefined opcodes (1000, 1010, 1100, 1101) SHALL act as NOP: clear carry, pc+1.
REQ-023 IN SHALL sample in_port during the EXEC cycle.
REQ-024 out_port SHALL change only on OUT B / OUT Im, and SHALL hold otherwise.
REQ-025 step SHALL be ignored outside HALT and while run=1; run deasserted mid-instruction SHALL let the current instruction retire, then HALT.
REQ-026 Simultaneous run=1 and step=1 in HALT SHALL behave as run=1.

Reset
REQ-027 rst_n=0 SHALL immediately force state=HALT, pc=RESET_PC, reg_a=0, reg_b=0, carry=0, ir=0, out_port=0, instr_done=0, busy=0.
REQ-028 Reset asserted during FETCH or EXEC SHALL abort the instruction with no partial register update.
REQ-029 After rst_n rises, the block SHALL remain in HALT until run or step.

Structure
REQ-030 Package minicpu_pkg SHALL hold the opcode enum (4-bit), the FSM state enum, and the instruction field widths.
REQ-031 The 4-bit adder with carry-out SHALL be a separate sub-module, minicpu_alu.
REQ-032 The ROM SHALL stay external; minicpu_ctrl SHALL contain no program storage.

Verification
REQ-033 Program {0x20,0x70,0x01,0x01,0x40,0x90,0xF6}, in_port=3, run=1 -> out_port=5 after 12 cycles; then pc=6, stays 6; instr_done every 2nd cycle.
REQ-034 MOV A,15; ADD A,1; JNC 0; run=1 -> reg_a=0, carry=1, JNC not taken (pc=3); next MOV clears carry.
REQ-035 Halted, run=0, three step pulses spaced 5 cycles -> exactly three instr_done pulses, pc advances by 3, busy high only 2 cycles per step.
REQ-036 rst_n low during EXEC of ADD A,1 with reg_a=4 -> reg_a=0, pc=RESET_PC, state HALT at once; no instr_done pulse.
REQ-037 Opcode 0xA5 at pc=15 -> NOP, carry=0, pc wraps to 0; out_port unchanged.
